// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic {
    DROP = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: PC register, BRAM enable, EX redirect handling,
// wrong-path drop FSM and taken-redirect counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        br_jal_success,
  input  logic [31:0] br_jal_pc,
  input  logic        alu_to_pc,
  input  logic [31:0] alu_y,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_err,
  output logic [31:0] redirect_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  cnt_q, cnt_d;

  logic         redirect;
  logic [31:0]  raw_target;
  logic [31:0]  target;
  logic         target_misaligned;

  always_comb begin
    redirect          = ex_valid & (alu_to_pc | br_jal_success);
    raw_target        = alu_to_pc ? {alu_y[31:1], 1'b0} : br_jal_pc;
    target_misaligned = raw_target[1];
    target            = target_misaligned ? {raw_target[31:2], 2'b00} : raw_target;

    // A redirect overrides stall: the stalled ID instruction is younger and gets flushed.
    imem_en = ~stall | redirect;

    pc_d = pc_q + PC_INCR;
    if (redirect) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = pc_q;
    end

    if_pc_d    = imem_en ? pc_q : if_pc_q;
    misalign_d = misalign_q | (redirect & target_misaligned);
    cnt_d      = cnt_q + {31'd0, redirect};

    state_d = state_q;
    unique case (state_q)
      DROP:    if (redirect) state_d = DROP;
               else if (imem_en) state_d = RUN;
      RUN:     if (redirect) state_d = DROP;
      default: state_d = DROP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DROP;
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_pc        = if_pc_q;
  assign if_valid     = (state_q == RUN);
  assign flush_ifid   = redirect;
  assign flush_idex   = redirect;
  assign misalign_err = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic        br_jal_success;
  logic [31:0] br_jal_pc;
  logic        alu_to_pc;
  logic [31:0] alu_y;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        misalign_err;
  logic [31:0] redirect_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .br_jal_success (br_jal_success),
    .br_jal_pc      (br_jal_pc),
    .alu_to_pc      (alu_to_pc),
    .alu_y          (alu_y),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .misalign_err   (misalign_err),
    .redirect_cnt   (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall          = 1'b0;
    ex_valid       = 1'b0;
    br_jal_success = 1'b0;
    br_jal_pc      = '0;
    alu_to_pc      = 1'b0;
    alu_y          = '0;
  endtask

  task automatic br_redirect(input logic [31:0] tgt);
    ex_valid       = 1'b1;
    br_jal_success = 1'b1;
    br_jal_pc      = tgt;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // cycle 0 after reset release
    check("rst_pc",       imem_addr,    32'h3000);
    check("rst_if_pc",    if_pc,        32'h3000);
    check("rst_valid",    {31'd0, if_valid},     32'd0);
    check("rst_cnt",      redirect_cnt, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_en",       {31'd0, imem_en},      32'd1);
    check("rst_flush",    {31'd0, flush_ifid},   32'd0);

    tick();
    check("run1_if_pc", if_pc, 32'h3000);
    check("run1_valid", {31'd0, if_valid}, 32'd1);
    check("run1_pc",    imem_addr, 32'h3004);
    tick();
    check("run2_if_pc", if_pc, 32'h3004);
    check("run2_valid", {31'd0, if_valid}, 32'd1);
    tick();
    check("run3_if_pc", if_pc, 32'h3008);
    check("run3_valid", {31'd0, if_valid}, 32'd1);
    check("run3_pc",    imem_addr, 32'h300C);

    // taken branch
    br_redirect(32'h3100);
    #1;
    check("br_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    check("br_flush_idex", {31'd0, flush_idex}, 32'd1);
    tick();
    clear_in();
    #1;
    check("br_t1_pc",    imem_addr, 32'h3100);
    check("br_t1_valid", {31'd0, if_valid}, 32'd0);
    check("br_t1_flush", {31'd0, flush_ifid}, 32'd0);
    tick();
    check("br_t2_if_pc", if_pc, 32'h3100);
    check("br_t2_valid", {31'd0, if_valid}, 32'd1);
    check("br_t2_cnt",   redirect_cnt, 32'd1);
    check("br_t2_pc",    imem_addr, 32'h3104);

    // jalr takes priority over a simultaneous taken branch; bit 0 dropped
    br_redirect(32'h4000);
    alu_to_pc = 1'b1;
    alu_y     = 32'h3201;
    #1;
    check("jalr_flush", {31'd0, flush_idex}, 32'd1);
    tick();
    clear_in();
    #1;
    check("jalr_pc",       imem_addr, 32'h3200);
    check("jalr_misalign", {31'd0, misalign_err}, 32'd0);
    check("jalr_cnt",      redirect_cnt, 32'd2);
    tick();
    check("jalr_if_pc", if_pc, 32'h3200);

    // misaligned jalr target
    ex_valid  = 1'b1;
    alu_to_pc = 1'b1;
    alu_y     = 32'h3206;
    tick();
    clear_in();
    #1;
    check("mis_pc",       imem_addr, 32'h3204);
    check("mis_flag",     {31'd0, misalign_err}, 32'd1);
    check("mis_cnt",      redirect_cnt, 32'd3);
    tick();
    check("mis_sticky",   {31'd0, misalign_err}, 32'd1);
    check("mis_if_pc",    if_pc, 32'h3204);
    check("mis_valid",    {31'd0, if_valid}, 32'd1);
    check("mis_pc_next",  imem_addr, 32'h3208);

    // back-to-back redirects
    br_redirect(32'h3400);
    tick();
    check("b2b_t1_pc",    imem_addr, 32'h3400);
    check("b2b_t1_valid", {31'd0, if_valid}, 32'd0);
    br_redirect(32'h3500);
    #1;
    check("b2b_flush2",   {31'd0, flush_ifid}, 32'd1);
    tick();
    clear_in();
    #1;
    check("b2b_t2_pc",    imem_addr, 32'h3500);
    check("b2b_t2_valid", {31'd0, if_valid}, 32'd0);
    check("b2b_t2_cnt",   redirect_cnt, 32'd5);
    tick();
    check("b2b_t3_if_pc", if_pc, 32'h3500);
    check("b2b_t3_valid", {31'd0, if_valid}, 32'd1);
    check("b2b_t3_pc",    imem_addr, 32'h3504);

    // stall freezes fetch
    stall = 1'b1;
    #1;
    check("stall_en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    imem_addr, 32'h3504);
      check("stall_if_pc", if_pc, 32'h3500);
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_en_hold", {31'd0, imem_en}, 32'd0);
    end
    // redirect beats stall
    br_redirect(32'h3300);
    #1;
    check("stallr_en",    {31'd0, imem_en}, 32'd1);
    check("stallr_flush", {31'd0, flush_ifid}, 32'd1);
    tick();
    clear_in();
    #1;
    check("stallr_pc",    imem_addr, 32'h3300);
    check("stallr_valid", {31'd0, if_valid}, 32'd0);
    check("stallr_if_pc", if_pc, 32'h3504);
    check("stallr_cnt",   redirect_cnt, 32'd6);
    tick();
    check("stallr_if_pc2", if_pc, 32'h3300);
    check("stallr_valid2", {31'd0, if_valid}, 32'd1);

    // bubble in EX: no redirect
    ex_valid       = 1'b0;
    br_jal_success = 1'b1;
    br_jal_pc      = 32'h3900;
    #1;
    check("bub_flush", {31'd0, flush_ifid}, 32'd0);
    check("bub_en",    {31'd0, imem_en}, 32'd1);
    tick();
    clear_in();
    #1;
    check("bub_pc",    imem_addr, 32'h3308);
    check("bub_cnt",   redirect_cnt, 32'd6);
    check("bub_valid", {31'd0, if_valid}, 32'd1);

    // PC wraps mod 2^32
    br_redirect(32'hFFFF_FFFC);
    tick();
    clear_in();
    #1;
    check("wrap_pc0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc1", imem_addr, 32'h0000_0000);
    check("wrap_cnt", redirect_cnt, 32'd7);

    // reset while in DROP and stalled
    br_redirect(32'h3600);
    tick();
    clear_in();
    stall = 1'b1;
    #1;
    check("pre_rst_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    check("rst2_pc",       imem_addr, 32'h3000);
    check("rst2_if_pc",    if_pc, 32'h3000);
    check("rst2_cnt",      redirect_cnt, 32'd0);
    check("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst2_valid",    {31'd0, if_valid}, 32'd0);
    tick();
    check("rst2_if_pc1", if_pc, 32'h3000);
    check("rst2_valid1", {31'd0, if_valid}, 32'd1);
    check("rst2_pc1",    imem_addr, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch control for the 5-stage RV32 pipeline. Owns the PC register, drives the synchronous instruction memory, and consumes the EX-stage redirect outputs (`br_jal_success`, `br_jal_pc`, `alu_to_pc`, `alu_y`). It turns a redirect into the PC update, the IF/ID and ID/EX flushes, and the drop of the one wrong-path word already in flight from the memory. It sits between the hazard unit and IF/ID and also keeps a taken-redirect performance counter.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk`  in  1: clock. Every register updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `stall`  in  1: load-use stall from the hazard unit. Holds PC and fetch.
- `ex_valid`  in  1: the EX-stage instruction is real, not a bubble.
- `br_jal_success`  in  1: taken branch or jal in EX.
- `br_jal_pc`  in  32: branch/jal target.
- `alu_to_pc`  in  1: jalr in EX.
- `alu_y`  in  32: jalr target (raw ALU sum).
- `imem_addr`  out  32: fetch address. Equals `pc`.
- `imem_en`  out  1: BRAM read enable. When low, the BRAM output register holds.
- `if_pc`  out  32: PC of the word currently on the imem output.
- `if_valid`  out  1: the imem output word is on the correct path.
- `flush_ifid`, `flush_idex`  out  1 each: load a bubble into that pipeline register.
- `misalign_err`  out  1: sticky flag. Set when a target has bit 1 set.
- `redirect_cnt`  out  32: count of taken redirects. Wraps.

## Operation
- Redirect condition: `redirect = ex_valid & (alu_to_pc | br_jal_success)`.
- Target selection: `alu_to_pc` has priority.
  - jalr target: `{alu_y[31:1],1'b0}`.
  - Otherwise: `br_jal_pc`.
- Misaligned target: if target bit 1 = 1, set `misalign_err` and load the target with bits [1:0] cleared.
- Enable: `imem_en = ~stall | redirect`. Redirect beats stall, because the stalled ID instruction is younger and is flushed.
- Next PC, in priority order:
  - `rst`: `RESET_PC`.
  - `redirect`: target.
  - `stall`: hold.
  - Otherwise: `pc+4`. Wraps mod 2^32.
- `if_pc <= pc` whenever `imem_en=1`. Otherwise hold.
- `flush_ifid = flush_idex = redirect`. These are combinational, same cycle as the redirect.
- FSM with two states, DROP and RUN. `if_valid = (state==RUN)`.
  - `rst` → DROP.
  - DROP & `redirect` → DROP.
  - DROP & `imem_en` & ~`redirect` → RUN.
  - DROP & ~`imem_en` → DROP.
  - RUN & `redirect` → DROP.
  - RUN otherwise → RUN. A stall leaves RUN unchanged.
- `redirect_cnt` increments by 1 on each cycle with `redirect=1`.
- Reset values: `pc=RESET_PC`, `if_pc=RESET_PC`, state=DROP, `if_valid=0`, `misalign_err=0`, `redirect_cnt=0`.
- Reset applied mid-DROP or mid-stall overrides everything.

## Timing
- Sequential fetch:
  - Address presented in cycle t.
  - At t+1 the word is on the imem output with `if_pc` = that address and `if_valid=1`.
- Redirect sampled in cycle t:
  - t: flushes high.
  - t+1: `pc`=target, `if_valid=0` (the wrong-path word fetched at t is dropped).
  - t+2: `if_pc`=target, `if_valid=1`.
- After reset release (cycle 0): `pc=RESET_PC`, `if_valid=0`. Cycle 1: `if_pc=RESET_PC`, `if_valid=1`, `pc=RESET_PC+4`.
- Stall: `pc`, `if_pc`, state, `if_valid` and the imem output are all frozen for exactly the stalled cycles.
- Back-to-back redirects in t and t+1: the second target wins, and `if_valid` stays 0 through t+2.

## Structure
- Shared package holds:
  - DROP/RUN state encoding.
  - Default `RESET_PC`.
  - The constant 4 for the PC increment.
- No sub-module. The target mux, PC register, FSM and counter are single-module RTL.

## Test plan
- Reset then free run. `rst` high 2 cycles, then low.
  - Cycle 0: `pc`=0x3000, `if_valid`=0.
  - Cycles 1–3: `if_pc` = 0x3000, 0x3004, 0x3008 with `if_valid`=1.
- Taken branch: `ex_valid`=1, `br_jal_success`=1, `br_jal_pc`=0x3100 at t.
  - t: flushes=1.
  - t+1: `pc`=0x3100, `if_valid`=0.
  - t+2: `if_pc`=0x3100, `if_valid`=1, `redirect_cnt`=1.
- jalr priority: `alu_to_pc`=1, `alu_y`=0x3201, together with `br_jal_success`=1, `br_jal_pc`=0x4000.
  - Response: `pc`=0x3200, `misalign_err`=0.
  - Follow-up: `alu_y`=0x3206 → `pc`=0x3204, `misalign_err`=1 and stays 1.
- Stall: `stall`=1 for 3 cycles.
  - During the stall: `imem_en`=0, `pc`/`if_pc`/`if_valid` unchanged.
  - Then stall=1 with a redirect to 0x3300: `imem_en`=1, `pc`=0x3300 next cycle.
- Bubble and reset:
  - `ex_valid`=0 with `br_jal_success`=1 → no flush, `pc`+4, counter unchanged.
  - `rst` asserted during DROP → `pc`=0x3000, `redirect_cnt`=0, `misalign_err`=0.
